// File: rtl/simon_pkg.sv
// -----------------------------------------------------------------------------
// simon_pkg
//   Shared types and constants for the Simon game front end.
//
//   btn_code_t  : 2-bit code of a push-button event.
//   BTN_U/L/R/D : codes for the up, left, right and down buttons.
//   N_BTN       : number of push-buttons.
//   prio_encode : lowest-index-wins encoder over a vector of rise pulses.
// -----------------------------------------------------------------------------
package simon_pkg;

  localparam int N_BTN = 4;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t BTN_U = 2'd0;
  localparam btn_code_t BTN_L = 2'd1;
  localparam btn_code_t BTN_R = 2'd2;
  localparam btn_code_t BTN_D = 2'd3;

  // Lowest set index wins. The scan runs from the top down so the last
  // assignment is made by the lowest set bit. An all-zero input gives BTN_U;
  // callers qualify the result with their own "any rise" flag.
  function automatic btn_code_t prio_encode(input logic [N_BTN-1:0] rise);
    btn_code_t code;
    code = BTN_U;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (rise[i]) begin
        code = btn_code_t'(i);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   One push-button input path: a two-flop synchroniser, a stability counter
//   and the debounced level. The level changes only after the synchronised
//   input has differed from it for DEBOUNCE_CYCLES consecutive clocks.
//
//   Parameters:
//     DEBOUNCE_CYCLES : clocks of stability needed to change the level (>= 2).
//
//   Ports:
//     clk    in   system clock
//     reset  in   asynchronous, active-high reset
//     btn    in   raw button, asynchronous to clk
//     level  out  debounced level
//     rise   out  one-clock pulse, high in the clock after level goes 0->1
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_meta;
  logic             r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta  <= 1'b0;
      r_sync  <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge value of the others (r_sync sees the old r_meta).
      r_meta <= btn;
      r_sync <= r_meta;
      r_rise <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        // Stable for long enough: accept the new value. The rise pulse is
        // registered alongside the level so both appear after the same edge.
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/btn_conditioner.sv
// -----------------------------------------------------------------------------
// btn_conditioner
//   Conditions the four raw push-buttons (U, L, R, D) for the Simon FSM:
//   per-button synchronise + debounce, lowest-index priority encode of the
//   rising edges, and a one-deep valid/take event register with a sticky
//   overrun flag.
//
//   Build option: define BTN_COND_AUTOREPEAT_EN to add auto-repeat. While the
//   most recently accepted button is the only one held, a synthetic press of
//   that button is injected every REPEAT_CYCLES clocks.
//
//   Parameters:
//     DEBOUNCE_CYCLES : debounce stability time in clocks (>= 2).
//     REPEAT_CYCLES   : auto-repeat period in clocks (auto-repeat build only).
//
//   Ports:
//     clk        in   system clock (100 MHz)
//     reset      in   asynchronous, active-high reset
//     btn[3:0]   in   raw buttons, active-high; bit0=U bit1=L bit2=R bit3=D
//     take       in   consumer strobe; pops the held event
//     btn_valid  out  an event is held
//     btn_val    out  code of the held event (kept after it is taken)
//     btn_level  out  debounced button levels
//     overrun    out  sticky; an event was dropped because one was held
// -----------------------------------------------------------------------------
module btn_conditioner
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 50_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn,
  input  logic             take,
  output logic             btn_valid,
  output btn_code_t        btn_val,
  output logic [N_BTN-1:0] btn_level,
  output logic             overrun
);

  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_rise_db;
  logic [N_BTN-1:0] w_rep_rise;
  logic [N_BTN-1:0] w_rise;
  logic             w_rise_any;
  btn_code_t        w_code;

  logic             r_valid;
  btn_code_t        r_val;
  logic             r_overrun;
  logic             w_valid_nxt;
  btn_code_t        w_val_nxt;
  logic             w_overrun_nxt;

  // ---------------------------------------------------------------------------
  // Per-button synchronise and debounce
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .reset(reset),
      .btn  (btn[i]),
      .level(w_level[i]),
      .rise (w_rise_db[i])
    );
  end

  // ---------------------------------------------------------------------------
  // Optional auto-repeat
  // ---------------------------------------------------------------------------
`ifdef BTN_COND_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES);
  localparam logic [REP_W-1:0] REP_MAX = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] r_rep_cnt;
  logic [N_BTN-1:0] w_rep_onehot;
  logic             w_hold_ok;
  logic             w_rep_fire;

  // The accepted button is whatever the event register last loaded; repeat
  // only runs while that button is held on its own.
  assign w_rep_onehot = N_BTN'(1) << r_val;
  assign w_hold_ok    = (w_level == w_rep_onehot);
  assign w_rep_fire   = w_hold_ok && (r_rep_cnt == REP_MAX);
  assign w_rep_rise   = w_rep_fire ? w_rep_onehot : '0;

  // A real rise restarts the period, so the first repeat lands REPEAT_CYCLES
  // clocks after the genuine press is presented to the event register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep_cnt <= '0;
    end else if (!w_hold_ok || (|w_rise_db) || w_rep_fire) begin
      r_rep_cnt <= '0;
    end else begin
      r_rep_cnt <= r_rep_cnt + REP_W'(1);
    end
  end
`else
  // REPEAT_CYCLES has no function in this build.
  logic w_unused_repeat_cfg;
  assign w_unused_repeat_cfg = (REPEAT_CYCLES > 1);
  assign w_rep_rise          = '0;
`endif

  // ---------------------------------------------------------------------------
  // Priority encoder: lowest index wins, losers are discarded silently
  // ---------------------------------------------------------------------------
  assign w_rise     = w_rise_db | w_rep_rise;
  assign w_rise_any = |w_rise;
  assign w_code     = prio_encode(w_rise);

  // ---------------------------------------------------------------------------
  // Event register
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: defaults come first so every path assigns every output and no
    // latch is inferred.
    w_valid_nxt   = r_valid;
    w_val_nxt     = r_val;
    w_overrun_nxt = r_overrun;
    if (w_rise_any) begin
      if (!r_valid || take) begin
        // Empty, or the held event is popped this same edge: load the new one.
        w_valid_nxt = 1'b1;
        w_val_nxt   = w_code;
      end else begin
        // Full and nobody is taking: keep the old event, flag the loss.
        w_overrun_nxt = 1'b1;
      end
    end else if (r_valid && take) begin
      w_valid_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_val     <= BTN_U;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= w_valid_nxt;
      r_val     <= w_val_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign btn_valid = r_valid;
  assign btn_val   = r_val;
  assign btn_level = w_level;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_btn_conditioner
//   Directed bench for btn_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=20.
//   Inputs change 1 time unit after a rising edge; that edge is "edge 0" and
//   later edges are counted from it. Outputs are sampled 1 unit after an edge.
// -----------------------------------------------------------------------------
module tb_btn_conditioner;
  import simon_pkg::*;

  localparam int DB = 4;
  localparam int RP = 20;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      btn = 4'b0000;
  logic            take = 1'b0;
  logic            btn_valid;
  btn_code_t       btn_val;
  logic [3:0]      btn_level;
  logic            overrun;

  int n_checks = 0;
  int n_fail   = 0;
  int n_ev;
  int ev_edge[3];

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_CYCLES  (RP)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .btn      (btn),
    .take     (take),
    .btn_valid(btn_valid),
    .btn_val  (btn_val),
    .btn_level(btn_level),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic take_pulse();
    take = 1'b1;
    step(1);
    take = 1'b0;
  endtask

  // Release every button and wait past the release debounce (level falls
  // DB+2 edges later).
  task automatic release_all();
    btn = 4'b0000;
    step(DB + 4);
  endtask

  initial begin
    // ---------------- reset state ----------------
    step(2);
    check("rst_valid", 32'(btn_valid), 0);
    check("rst_val", 32'(btn_val), 0);
    check("rst_level", 32'(btn_level), 0);
    check("rst_overrun", 32'(overrun), 0);
    reset = 1'b0;
    step(3);

    // ---------------- clean press of L ----------------
    btn = 4'b0010;
    step(5);
    check("clean_level_e5", 32'(btn_level), 0);
    step(1);
    check("clean_level_e6", 32'(btn_level), 32'b0010);
    check("clean_valid_e6", 32'(btn_valid), 0);
    step(1);
    check("clean_valid_e7", 32'(btn_valid), 1);
    check("clean_val_e7", 32'(btn_val), 1);
    take_pulse();
    check("clean_take_valid", 32'(btn_valid), 0);
    check("clean_take_val", 32'(btn_val), 1);
    step(2);
    btn = 4'b0000;
    step(5);
    check("clean_rel_e5", 32'(btn_level), 32'b0010);
    step(1);
    check("clean_rel_e6", 32'(btn_level), 0);
    check("clean_rel_noevent", 32'(btn_valid), 0);
    step(2);
    take_pulse();
    check("take_when_empty", 32'(btn_valid), 0);

    // ---------------- bounce on R ----------------
    for (int s = 0; s < 6; s++) begin
      btn = (s % 2 == 0) ? 4'b0100 : 4'b0000;
      for (int c = 0; c < 2; c++) begin
        step(1);
        check("bounce_level", 32'(btn_level), 0);
        check("bounce_valid", 32'(btn_valid), 0);
      end
    end
    btn = 4'b0100;
    step(6);
    check("bounce_settle_e6", 32'(btn_valid), 0);
    step(1);
    check("bounce_settle_valid", 32'(btn_valid), 1);
    check("bounce_settle_val", 32'(btn_val), 2);
    take_pulse();
    release_all();
    check("bounce_single_event", 32'(btn_valid), 0);

    // ---------------- simultaneous presses ----------------
    btn = 4'b1100;
    step(7);
    check("simul_rd_valid", 32'(btn_valid), 1);
    check("simul_rd_val", 32'(btn_val), 2);
    check("simul_rd_overrun", 32'(overrun), 0);
    take_pulse();
    release_all();
    btn = 4'b0011;
    step(7);
    check("simul_ul_valid", 32'(btn_valid), 1);
    check("simul_ul_val", 32'(btn_val), 0);
    check("simul_ul_overrun", 32'(overrun), 0);
    release_all();

    // ---------------- overrun: U still held, D pressed ----------------
    btn = 4'b1000;
    step(7);
    check("ovr_valid", 32'(btn_valid), 1);
    check("ovr_val_kept", 32'(btn_val), 0);
    check("ovr_flag", 32'(overrun), 1);
    release_all();

    // ---------------- take coincident with a new rise ----------------
    btn = 4'b0100;
    step(6);
    take = 1'b1;
    step(1);
    take = 1'b0;
    check("take_rise_valid", 32'(btn_valid), 1);
    check("take_rise_val", 32'(btn_val), 2);
    check("take_rise_overrun", 32'(overrun), 1);
    step(1);

    // ---------------- reset mid-debounce / mid-event ----------------
    btn = 4'b0001;
    step(3);
    reset = 1'b1;
    #1;
    check("midrst_valid", 32'(btn_valid), 0);
    check("midrst_val", 32'(btn_val), 0);
    check("midrst_level", 32'(btn_level), 0);
    check("midrst_overrun", 32'(overrun), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(6);
    check("postrst_e6_valid", 32'(btn_valid), 0);
    step(1);
    check("postrst_e7_valid", 32'(btn_valid), 1);
    check("postrst_e7_val", 32'(btn_val), 0);
    take_pulse();
    release_all();

    // ---------------- auto-repeat on D ----------------
    btn  = 4'b1000;
    n_ev = 0;
    for (int e = 1; e <= 60; e++) begin
      step(1);
      take = 1'b0;
      if (btn_valid) begin
        if (n_ev < 3) ev_edge[n_ev] = e;
        n_ev++;
        take = 1'b1;
      end
    end
    take = 1'b0;
`ifdef BTN_COND_AUTOREPEAT_EN
    check("rep_count", 32'(n_ev), 3);
    if (n_ev >= 3) begin
      check("rep_ev0", 32'(ev_edge[0]), 7);
      check("rep_ev1", 32'(ev_edge[1]), 27);
      check("rep_ev2", 32'(ev_edge[2]), 47);
    end
`else
    check("rep_count", 32'(n_ev), 1);
    if (n_ev >= 1) begin
      check("rep_ev0", 32'(ev_edge[0]), 7);
    end
`endif
    release_all();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
